can_tx_sched: RTL and testbench

CAN_TX_SCHED -- requirements
Module: can_tx_sched

---
 rtl/can_tx_sched_if.sv | 12 +
 rtl/can_tx_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_can_tx_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_sched_if.sv
// Register port between the transmit scheduler (master) and the CAN core (slave).
// can_q is combinational from the core and valid in the same cycle as can_cs.
interface can_tx_sched_if;
    logic        can_cs;
    logic [1:0]  can_rs;
    logic [3:0]  can_bytesel;
    logic [31:0] can_d;
    logic [31:0] can_q;

    modport master (output can_cs, can_rs, can_bytesel, can_d, input  can_q);
    modport slave  (input  can_cs, can_rs, can_bytesel, can_d, output can_q);
endinterface

// File: rtl/can_tx_sched.sv
// Four-mailbox CAN transmit scheduler with retry, abort and sticky done/err flags.
// Define CAN_SCHED_PRIO_EN to pick the next mailbox by CAN identifier priority instead of index.
module can_tx_sched #(
    parameter int MAX_RETRY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mb_wr,
    input  logic [1:0]            mb_sel,
    input  logic [1:0]            mb_field,
    input  logic [31:0]           mb_wdata,
    input  logic [3:0]            mb_send,
    input  logic [3:0]            mb_abort,
    input  logic [3:0]            mb_ack,
    output logic [3:0]            mb_pending,
    output logic [3:0]            mb_done,
    output logic [3:0]            mb_err,
    output logic                  irq,
    can_tx_sched_if.master        can
);
    typedef enum logic [2:0] {IDLE, BUSYCHK, SCAN, WR_ID, WR_D0, WR_D1, WR_DLC, WAIT} state_t;

    localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);
    localparam int RTS_BIT  = 8;
    localparam int LOST_BIT = 9;
    localparam int BERR_BIT = 10;
    localparam int ACK_BIT  = 11;

    state_t            state_q, state_d;
    logic [1:0]        scan_idx_q, scan_idx_d;
    logic [1:0]        win_q, win_d;
    logic              win_vld_q, win_vld_d;
    logic              abort_q, abort_d;
    logic [3:0]        pending_q, pending_d;
    logic [3:0]        done_q, done_d;
    logic [3:0]        err_q, err_d;
    logic [3:0][3:0]   retry_q, retry_d;
    logic [3:0][31:0]  id_q, id_d, data0_q, data0_d, data1_q, data1_d;
    logic [3:0][3:0]   dlc_q, dlc_d;

    logic [3:0]        pend_live;
    logic              take_cand, win_live, active, fin, tx_ok;

    assign pend_live = pending_q & ~mb_abort;
    assign win_live  = win_vld_q && pend_live[win_q];
    assign active    = state_q inside {WR_ID, WR_D0, WR_D1, WR_DLC, WAIT};
    assign fin       = (state_q == WAIT) && !can.can_q[RTS_BIT];
    assign tx_ok     = can.can_q[ACK_BIT] && !can.can_q[LOST_BIT] && !can.can_q[BERR_BIT];

`ifdef CAN_SCHED_PRIO_EN
    logic [29:0] win_key_q, win_key_d, cand_key;
    // Standard IDs sort ahead of extended IDs sharing the same 11-bit base.
    assign cand_key  = id_q[scan_idx_q][31] ? {id_q[scan_idx_q][28:18], 1'b1, id_q[scan_idx_q][17:0]}
                                            : {id_q[scan_idx_q][10:0], 1'b0, 18'h0};
    assign take_cand = pend_live[scan_idx_q] && (!win_vld_q || (cand_key < win_key_q));
`else
    assign take_cand = pend_live[scan_idx_q] && !win_vld_q;
`endif

    assign mb_pending = pending_q;
    assign mb_done    = done_q;
    assign mb_err     = err_q;
    assign irq        = |(done_q | err_q);

    always_comb begin
        id_d    = id_q;
        dlc_d   = dlc_q;
        data0_d = data0_q;
        data1_d = data1_q;
        if (mb_wr && !pending_q[mb_sel]) begin
            case (mb_field)
                2'd0:    id_d[mb_sel]    = mb_wdata;
                2'd1:    dlc_d[mb_sel]   = mb_wdata[3:0];
                2'd2:    data0_d[mb_sel] = mb_wdata;
                default: data1_d[mb_sel] = mb_wdata;
            endcase
        end
    end

    always_comb begin
        state_d         = state_q;
        scan_idx_d      = scan_idx_q;
        win_d           = win_q;
        win_vld_d       = win_vld_q;
`ifdef CAN_SCHED_PRIO_EN
        win_key_d       = win_key_q;
`endif
        can.can_cs      = 1'b0;
        can.can_rs      = 2'd0;
        can.can_bytesel = 4'b0000;
        can.can_d       = 32'h0;
        case (state_q)
            IDLE: begin
                win_vld_d = 1'b0;
                if (|pending_q) state_d = BUSYCHK;
            end
            BUSYCHK: begin
                can.can_cs = 1'b1;
                can.can_rs = 2'd1;
                if (!can.can_q[RTS_BIT]) begin
                    state_d    = SCAN;
                    scan_idx_d = 2'd0;
                    win_vld_d  = 1'b0;
                end
            end
            SCAN: begin
                scan_idx_d = scan_idx_q + 2'd1;
                if (take_cand) begin
                    win_d     = scan_idx_q;
                    win_vld_d = 1'b1;
`ifdef CAN_SCHED_PRIO_EN
                    win_key_d = cand_key;
`endif
                end
                if (scan_idx_q == 2'd3) state_d = (take_cand || win_live) ? WR_ID : IDLE;
            end
            WR_ID: begin
                can.can_cs      = 1'b1;
                can.can_bytesel = 4'b1111;
                can.can_d       = id_q[win_q];
                state_d         = WR_D0;
            end
            WR_D0: begin
                can.can_cs      = 1'b1;
                can.can_rs      = 2'd2;
                can.can_bytesel = 4'b1111;
                can.can_d       = data0_q[win_q];
                state_d         = WR_D1;
            end
            WR_D1: begin
                can.can_cs      = 1'b1;
                can.can_rs      = 2'd3;
                can.can_bytesel = 4'b1111;
                can.can_d       = data1_q[win_q];
                state_d         = WR_DLC;
            end
            WR_DLC: begin
                // Only the low two byte lanes are written so baud and irq-enable bits survive.
                can.can_cs      = 1'b1;
                can.can_rs      = 2'd1;
                can.can_bytesel = 4'b0011;
                can.can_d       = {23'b0, 1'b1, 4'b0, dlc_q[win_q]};
                state_d         = WAIT;
            end
            WAIT: begin
                can.can_cs = 1'b1;
                can.can_rs = 2'd1;
                if (!can.can_q[RTS_BIT]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        done_d    = done_q;
        err_d     = err_q;
        retry_d   = retry_q;
        abort_d   = abort_q;
        for (int i = 0; i < 4; i++) begin
            if (mb_ack[i]) begin
                done_d[i] = 1'b0;
                err_d[i]  = 1'b0;
            end
            if (mb_send[i] && !mb_abort[i]) begin
                pending_d[i] = 1'b1;
                done_d[i]    = 1'b0;
                err_d[i]     = 1'b0;
                retry_d[i]   = 4'd0;
            end
            if (mb_abort[i]) begin
                if (active && (win_q == 2'(i))) abort_d = 1'b1;
                else                            pending_d[i] = 1'b0;
            end
        end
        // An aborted in-flight frame still runs to completion, then retires silently.
        if (fin) begin
            abort_d = 1'b0;
            if (abort_q || mb_abort[win_q]) begin
                pending_d[win_q] = 1'b0;
                done_d[win_q]    = 1'b0;
                err_d[win_q]     = 1'b0;
            end else if (tx_ok) begin
                pending_d[win_q] = 1'b0;
                done_d[win_q]    = 1'b1;
            end else if (retry_q[win_q] < MAX_RETRY_C) begin
                retry_d[win_q]   = retry_q[win_q] + 4'd1;
            end else begin
                pending_d[win_q] = 1'b0;
                err_d[win_q]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        id_q    <= id_d;
        dlc_q   <= dlc_d;
        data0_q <= data0_d;
        data1_q <= data1_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            scan_idx_q <= 2'd0;
            win_q      <= 2'd0;
            win_vld_q  <= 1'b0;
            abort_q    <= 1'b0;
            pending_q  <= 4'b0;
            done_q     <= 4'b0;
            err_q      <= 4'b0;
            retry_q    <= '0;
`ifdef CAN_SCHED_PRIO_EN
            win_key_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            win_q      <= win_d;
            win_vld_q  <= win_vld_d;
            abort_q    <= abort_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            err_q      <= err_d;
            retry_q    <= retry_d;
`ifdef CAN_SCHED_PRIO_EN
            win_key_q  <= win_key_d;
`endif
        end
    end
endmodule

// File: tb/tb_can_tx_sched.sv
// Directed bench for can_tx_sched; a small behavioural CAN core answers status reads
// and logs every register write the scheduler issues.
module tb_can_tx_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mb_wr = 1'b0;
    logic [1:0]  mb_sel = 2'd0;
    logic [1:0]  mb_field = 2'd0;
    logic [31:0] mb_wdata = 32'h0;
    logic [3:0]  mb_send = 4'b0, mb_abort = 4'b0, mb_ack = 4'b0;
    logic [3:0]  mb_pending, mb_done, mb_err;
    logic        irq;

    can_tx_sched_if cif();

    can_tx_sched #(.MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .mb_wr(mb_wr), .mb_sel(mb_sel), .mb_field(mb_field),
        .mb_wdata(mb_wdata), .mb_send(mb_send), .mb_abort(mb_abort), .mb_ack(mb_ack),
        .mb_pending(mb_pending), .mb_done(mb_done), .mb_err(mb_err), .irq(irq), .can(cif)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    logic [31:0] core_status = 32'h0, result_status = 32'h800;
    int poll_busy = 0, busy_left = 0, hold_rts = 0;
    int log_cnt = 0, status_reads = 0, busy_reads = 0, reads_at_first_wr = -1, strobes = 0;
    int bad_access = 0, bad_idle = 0, wr_busy_viol = 0;
    logic [1:0]  log_rs [64];
    logic [3:0]  log_bs [64];
    logic [31:0] log_d  [64];

    assign cif.can_q = core_status;

    // Core model: decides the status seen at the coming rising edge for each status read.
    always @(negedge clk) begin
        if (cif.can_cs === 1'b1 && cif.can_bytesel != 4'b0000) begin
            if (log_cnt == 0) reads_at_first_wr = status_reads;
            if (log_cnt < 64) begin
                log_rs[log_cnt] = cif.can_rs;
                log_bs[log_cnt] = cif.can_bytesel;
                log_d[log_cnt]  = cif.can_d;
            end
            log_cnt++;
            if (hold_rts > 0 || busy_left > 0) wr_busy_viol++;
            if (cif.can_rs == 2'd1 && cif.can_d[8]) begin
                strobes++;
                busy_left = poll_busy;
            end
        end else if (cif.can_cs === 1'b1 && cif.can_rs == 2'd1) begin
            status_reads++;
            if (hold_rts > 0) begin
                core_status = 32'h100; hold_rts--; busy_reads++;
            end else if (busy_left > 0) begin
                core_status = 32'h100; busy_left--; busy_reads++;
            end else begin
                core_status = result_status;
            end
        end
        if (cif.can_cs === 1'b1 && cif.can_rs == 2'd0 && cif.can_bytesel == 4'b0000) bad_access++;
        if (cif.can_cs === 1'b0 && (cif.can_bytesel != 4'b0000 || cif.can_d != 32'h0)) bad_idle++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        log_cnt = 0; status_reads = 0; busy_reads = 0; reads_at_first_wr = -1; strobes = 0;
    endtask

    task automatic write_mb(input logic [1:0] sel, input logic [1:0] fld, input logic [31:0] dat);
        mb_wr = 1'b1; mb_sel = sel; mb_field = fld; mb_wdata = dat;
        step();
        mb_wr = 1'b0;
    endtask

    task automatic load_mb(input logic [1:0] sel, input logic [31:0] id, input logic [3:0] dlc,
                           input logic [31:0] d0, input logic [31:0] d1);
        write_mb(sel, 2'd0, id);
        write_mb(sel, 2'd1, {28'h0, dlc});
        write_mb(sel, 2'd2, d0);
        write_mb(sel, 2'd3, d1);
    endtask

    task automatic pulse(input logic [3:0] s, input logic [3:0] a, input logic [3:0] k);
        mb_send = s; mb_abort = a; mb_ack = k;
        step();
        mb_send = 4'b0; mb_abort = 4'b0; mb_ack = 4'b0;
    endtask

    task automatic wait_clear(input logic [3:0] mask, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if ((mb_pending & mask) == 4'b0) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++; if (mb_pending !== 4'b0) begin bad++; $display("[TB] FAIL rst_pending got=%b want=0000", mb_pending); end
        total++; if (mb_done !== 4'b0) begin bad++; $display("[TB] FAIL rst_done got=%b want=0000", mb_done); end
        total++; if (mb_err !== 4'b0) begin bad++; $display("[TB] FAIL rst_err got=%b want=0000", mb_err); end
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rst_irq got=%b want=0", irq); end
        total++; if ({cif.can_cs, cif.can_rs, cif.can_bytesel, cif.can_d} !== 39'h0) begin
            bad++; $display("[TB] FAIL rst_bus got cs=%b rs=%0d bs=%b d=%h want all 0",
                            cif.can_cs, cif.can_rs, cif.can_bytesel, cif.can_d);
        end
        rst = 1'b0;
        step();
        bad_access = 0; bad_idle = 0; wr_busy_viol = 0;
    endtask

    task automatic test_basic();
        bit ok;
        load_mb(2'd1, 32'h0000_0123, 4'd8, 32'h1122_3344, 32'h5566_7788);
        poll_busy = 5; result_status = 32'h800; clear_log();
        pulse(4'b0010, 4'b0, 4'b0);
        total++; if (mb_pending !== 4'b0010) begin bad++; $display("[TB] FAIL basic_pend_set got=%b want=0010", mb_pending); end
        wait_clear(4'b0010, 200, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL basic_timeout got=%b want=1", ok); end
        total++; if (log_cnt !== 4) begin bad++; $display("[TB] FAIL basic_wr_count got=%0d want=4", log_cnt); end
        total++; if ({log_rs[0], log_bs[0], log_d[0]} !== {2'd0, 4'hF, 32'h0000_0123}) begin
            bad++; $display("[TB] FAIL basic_wr_id got rs=%0d bs=%b d=%h want rs=0 bs=1111 d=00000123", log_rs[0], log_bs[0], log_d[0]); end
        total++; if ({log_rs[1], log_bs[1], log_d[1]} !== {2'd2, 4'hF, 32'h1122_3344}) begin
            bad++; $display("[TB] FAIL basic_wr_d0 got rs=%0d bs=%b d=%h want rs=2 bs=1111 d=11223344", log_rs[1], log_bs[1], log_d[1]); end
        total++; if ({log_rs[2], log_bs[2], log_d[2]} !== {2'd3, 4'hF, 32'h5566_7788}) begin
            bad++; $display("[TB] FAIL basic_wr_d1 got rs=%0d bs=%b d=%h want rs=3 bs=1111 d=55667788", log_rs[2], log_bs[2], log_d[2]); end
        total++; if ({log_rs[3], log_bs[3], log_d[3]} !== {2'd1, 4'h3, 32'h0000_0108}) begin
            bad++; $display("[TB] FAIL basic_wr_dlc got rs=%0d bs=%b d=%h want rs=1 bs=0011 d=00000108", log_rs[3], log_bs[3], log_d[3]); end
        total++; if (busy_reads !== 5) begin bad++; $display("[TB] FAIL basic_polls got=%0d want=5", busy_reads); end
        total++; if ({mb_done, mb_err, mb_pending, irq} !== {4'b0010, 4'b0, 4'b0, 1'b1}) begin
            bad++; $display("[TB] FAIL basic_flags got done=%b err=%b pend=%b irq=%b want 0010 0000 0000 1", mb_done, mb_err, mb_pending, irq); end
        pulse(4'b0, 4'b0, 4'b0010);
        total++; if ({mb_done, irq} !== 5'b0) begin bad++; $display("[TB] FAIL basic_ack got done=%b irq=%b want 0000 0", mb_done, irq); end
    endtask

    task automatic test_priority();
        bit ok;
        logic [31:0] first_id, second_id;
`ifdef CAN_SCHED_PRIO_EN
        first_id = 32'h001; second_id = 32'h7FF;
`else
        first_id = 32'h7FF; second_id = 32'h001;
`endif
        load_mb(2'd0, 32'h0000_07FF, 4'd1, 32'hA0A0_A0A0, 32'hA1A1_A1A1);
        load_mb(2'd3, 32'h0000_0001, 4'd1, 32'hB0B0_B0B0, 32'hB1B1_B1B1);
        poll_busy = 1; result_status = 32'h800; clear_log();
        pulse(4'b1001, 4'b0, 4'b0);
        wait_clear(4'b1001, 400, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL prio_timeout got=%b want=1", ok); end
        total++; if (log_cnt !== 8) begin bad++; $display("[TB] FAIL prio_wr_count got=%0d want=8", log_cnt); end
        total++; if (log_d[0] !== first_id) begin bad++; $display("[TB] FAIL prio_first got=%h want=%h", log_d[0], first_id); end
        total++; if (log_d[4] !== second_id) begin bad++; $display("[TB] FAIL prio_second got=%h want=%h", log_d[4], second_id); end
        total++; if (mb_done !== 4'b1001) begin bad++; $display("[TB] FAIL prio_done got=%b want=1001", mb_done); end
        pulse(4'b0, 4'b0, 4'b1001);
    endtask

    task automatic test_retry(input logic [31:0] st, input logic [1:0] idx);
        bit ok;
        logic [3:0] mask;
        mask = 4'b0001 << idx;
        load_mb(idx, 32'h0000_0042, 4'd2, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        poll_busy = 2; result_status = st; clear_log();
        pulse(mask, 4'b0, 4'b0);
        wait_clear(mask, 1000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL retry_timeout st=%h got=%b want=1", st, ok); end
        total++; if (strobes !== 4) begin bad++; $display("[TB] FAIL retry_attempts st=%h got=%0d want=4", st, strobes); end
        total++; if ({mb_err, mb_done, irq} !== {mask, 4'b0, 1'b1}) begin
            bad++; $display("[TB] FAIL retry_flags st=%h got err=%b done=%b irq=%b want err=%b done=0000 irq=1", st, mb_err, mb_done, irq, mask); end
        pulse(4'b0, 4'b0, mask);
        total++; if (mb_err !== 4'b0) begin bad++; $display("[TB] FAIL retry_ack got=%b want=0000", mb_err); end
    endtask

    task automatic test_abort();
        bit ok;
        load_mb(2'd2, 32'h8000_0ABC, 4'd2, 32'h0102_0304, 32'h0506_0708);
        poll_busy = 8; result_status = 32'h800; clear_log();
        pulse(4'b0100, 4'b0, 4'b0);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (strobes == 1) begin ok = 1'b1; break; end
            step();
        end
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL abort_reach_wait got=%b want=1", ok); end
        pulse(4'b0, 4'b0100, 4'b0);
        total++; if (mb_pending !== 4'b0100) begin bad++; $display("[TB] FAIL abort_inflight_pend got=%b want=0100", mb_pending); end
        wait_clear(4'b0100, 100, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL abort_timeout got=%b want=1", ok); end
        step(); step(); step();
        total++; if ({mb_done, mb_err, mb_pending} !== 12'h0) begin
            bad++; $display("[TB] FAIL abort_flags got done=%b err=%b pend=%b want all 0000", mb_done, mb_err, mb_pending); end
        total++; if (strobes !== 1) begin bad++; $display("[TB] FAIL abort_no_retry got=%0d want=1", strobes); end

        clear_log();
        pulse(4'b0010, 4'b0010, 4'b0);
        total++; if (mb_pending !== 4'b0) begin bad++; $display("[TB] FAIL abort_same_cycle got=%b want=0000", mb_pending); end
        for (int n = 0; n < 10; n++) step();
        total++; if (status_reads + log_cnt !== 0) begin bad++; $display("[TB] FAIL abort_same_cycle_bus got=%0d want=0", status_reads + log_cnt); end

        hold_rts = 10; clear_log();
        pulse(4'b0001, 4'b0, 4'b0);
        step();
        pulse(4'b0, 4'b0001, 4'b0);
        total++; if (mb_pending !== 4'b0) begin bad++; $display("[TB] FAIL abort_idle_pend got=%b want=0000", mb_pending); end
        for (int n = 0; n < 30; n++) step();
        total++; if (log_cnt !== 0) begin bad++; $display("[TB] FAIL abort_idle_writes got=%0d want=0", log_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        load_mb(2'd0, 32'h0000_0456, 4'd4, 32'hC0C0_C0C0, 32'hC1C1_C1C1);
        poll_busy = 1; result_status = 32'h800; clear_log();
        pulse(4'b0001, 4'b0, 4'b0);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (log_cnt == 2) begin ok = 1'b1; break; end
            step();
        end
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rmid_reach_d1 got=%b want=1", ok); end
        rst = 1'b1;
        step();
        rst = 1'b0; hold_rts = 20; core_status = 32'h100; clear_log();
        total++; if ({mb_pending, cif.can_cs} !== 5'b0) begin
            bad++; $display("[TB] FAIL rmid_cleared got pend=%b cs=%b want 0000 0", mb_pending, cif.can_cs); end
        pulse(4'b0001, 4'b0, 4'b0);
        write_mb(2'd0, 2'd0, 32'h0000_0ABC);
        wait_clear(4'b0001, 300, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rmid_timeout got=%b want=1", ok); end
        total++; if (reads_at_first_wr !== 21) begin bad++; $display("[TB] FAIL rmid_busychk_reads got=%0d want=21", reads_at_first_wr); end
        total++; if (wr_busy_viol !== 0) begin bad++; $display("[TB] FAIL rmid_write_while_busy got=%0d want=0", wr_busy_viol); end
        total++; if ({log_rs[0], log_bs[0], log_d[0]} !== {2'd0, 4'hF, 32'h0000_0456}) begin
            bad++; $display("[TB] FAIL rmid_id_kept got rs=%0d bs=%b d=%h want rs=0 bs=1111 d=00000456", log_rs[0], log_bs[0], log_d[0]); end
        total++; if (log_d[3] !== 32'h0000_0104) begin bad++; $display("[TB] FAIL rmid_dlc got=%h want=00000104", log_d[3]); end
        total++; if (mb_done !== 4'b0001) begin bad++; $display("[TB] FAIL rmid_done got=%b want=0001", mb_done); end
        pulse(4'b0, 4'b0, 4'b0001);
    endtask

    task automatic test_bus_rules();
        total++; if (bad_access !== 0) begin bad++; $display("[TB] FAIL bus_rs0_read got=%0d want=0", bad_access); end
        total++; if (bad_idle !== 0) begin bad++; $display("[TB] FAIL bus_idle_quiet got=%0d want=0", bad_idle); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_priority();
        test_retry(32'h200, 2'd2);
        test_retry(32'hA00, 2'd1);
        test_retry(32'hC00, 2'd3);
        test_abort();
        test_reset_mid();
        test_bus_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
